udp_img_pkt_src: RTL and testbench

//  User-side packet source for the UDP transmitter. Runs on gmii_tx_clk.

---
 rtl/udp_img_pkt_src.sv | 144 ++++++++++++++
 tb/tb_udp_img_pkt_src.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_img_pkt_src.sv
// udp_img_pkt_src: feeds the UDP transmitter with fixed-size payloads. Each payload is
// one header word followed by PKT_WORDS words read from the camera pixel FIFO.
module udp_img_pkt_src #(
    parameter int         PKT_WORDS      = 320,
    parameter int         PKTS_PER_FRAME = 480,
    parameter logic [7:0] CAM_ID         = 8'd0,
    parameter int         GAP_CYC        = 16,
    parameter int         USEDW_W        = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               transfer_en,
    input  logic               frame_start,
    output logic               fifo_rd_en,
    input  logic [31:0]        fifo_rd_data,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic               tx_start_en,
    output logic [15:0]        tx_byte_num,
    input  logic               tx_req,
    output logic [31:0]        tx_data,
    input  logic               tx_done,
    output logic               frame_done,
    output logic               busy
);

    localparam int CNT_W = $clog2(PKT_WORDS + 2);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [CNT_W-1:0]   LAST_WORD = CNT_W'(PKT_WORDS);
    localparam logic [CNT_W-1:0]   SAT_CNT   = CNT_W'(PKT_WORDS + 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [15:0]        LAST_PKT  = 16'(PKTS_PER_FRAME - 1);
    localparam logic [15:0]        BYTE_NUM  = 16'((PKT_WORDS + 1) * 4);
    localparam logic [USEDW_W-1:0] USEDW_MIN = USEDW_W'(PKT_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_SEND,
        S_GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [15:0]      pkt_idx;
    logic [7:0]       frame_cnt;
    logic [31:0]      data_q;
    logic             rd_pending;
    logic             data_phase;
    logic [31:0]      header;

    assign header     = {8'hAA, CAM_ID, frame_cnt, pkt_idx[7:0]};
    assign data_phase = (word_cnt != '0) && (word_cnt <= LAST_WORD);

    // NOTE: the read strobe is combinational on tx_req so the normal-mode FIFO returns
    // the word exactly one clock after the request; registering it would add a cycle.
    assign fifo_rd_en = (state == S_SEND) && tx_req && data_phase;

    // In the clock after a read the FIFO output is passed straight through; data_q
    // captures it so the last word stays on tx_data once reads stop.
    assign tx_data = rd_pending ? fifo_rd_data : data_q;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            word_cnt    <= '0;
            gap_cnt     <= '0;
            pkt_idx     <= '0;
            frame_cnt   <= '0;
            data_q      <= '0;
            rd_pending  <= 1'b0;
            tx_start_en <= 1'b0;
            tx_byte_num <= '0;
            frame_done  <= 1'b0;
        end else begin
            tx_start_en <= 1'b0;
            frame_done  <= 1'b0;
            rd_pending  <= fifo_rd_en;
            if (rd_pending) begin
                data_q <= fifo_rd_data;
            end

            case (state)
                S_IDLE: begin
                    if (frame_start && transfer_en) begin
                        pkt_idx <= '0;
                        state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (fifo_usedw >= USEDW_MIN) begin
                        tx_start_en <= 1'b1;
                        tx_byte_num <= BYTE_NUM;
                        state       <= S_START;
                    end
                end

                S_START: begin
                    word_cnt <= '0;
                    gap_cnt  <= '0;
                    state    <= tx_done ? S_GAP : S_SEND;
                end

                S_SEND: begin
                    if (tx_req) begin
                        if (word_cnt == '0) begin
                            data_q <= header;
                        end
                        if (word_cnt != SAT_CNT) begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                    if (tx_done) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (pkt_idx < LAST_PKT) begin
                            pkt_idx <= pkt_idx + 16'd1;
                            state   <= S_WAIT;
                        end else begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            pkt_idx    <= '0;
                            state      <= S_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_img_pkt_src.sv
// tb_udp_img_pkt_src: random FIFO contents and transmitter timing; a scoreboard queue of
// expected payload words is filled by the driver and drained by a tx_data monitor.
module tb_udp_img_pkt_src;

    localparam int         PW    = 4;
    localparam int         PPF   = 3;
    localparam int         GAP   = 4;
    localparam int         UW    = 12;
    localparam logic [7:0] CAM   = 8'd3;
    localparam logic [15:0] BYTES = 16'd20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          transfer_en = 1'b0;
    logic          frame_start = 1'b0;
    logic          tx_req = 1'b0;
    logic          tx_done = 1'b0;
    logic          fifo_rd_en;
    logic          tx_start_en;
    logic          frame_done;
    logic          busy;
    logic [31:0]   fifo_rd_data = '0;
    logic [31:0]   tx_data;
    logic [UW-1:0] fifo_usedw;
    logic [15:0]   tx_byte_num;

    always #5 clk = ~clk;

    udp_img_pkt_src #(
        .PKT_WORDS      (PW),
        .PKTS_PER_FRAME (PPF),
        .CAM_ID         (CAM),
        .GAP_CYC        (GAP),
        .USEDW_W        (UW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .transfer_en  (transfer_en),
        .frame_start  (frame_start),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_usedw   (fifo_usedw),
        .tx_start_en  (tx_start_en),
        .tx_byte_num  (tx_byte_num),
        .tx_req       (tx_req),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Normal-mode FIFO model: data appears on fifo_rd_data the clock after the read strobe.
    logic [31:0] fifo_q[$];
    int          push_cnt = 0;
    int          pop_cnt = 0;
    bit          usedw_hold = 1'b0;
    int          usedw_val = 0;

    assign fifo_usedw = usedw_hold ? UW'(usedw_val) : UW'(push_cnt - pop_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_rd_data <= fifo_q.pop_front();
            pop_cnt      <= pop_cnt + 1;
        end
    end

    int   rd_total = 0;
    int   start_total = 0;
    int   fd_total = 0;
    int   cyc = 0;
    logic req_d = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        req_d <= tx_req;
        if (fifo_rd_en)  rd_total    <= rd_total + 1;
        if (tx_start_en) start_total <= start_total + 1;
        if (frame_done)  fd_total    <= fd_total + 1;
    end

    // Scoreboard: one expected word per tx_req, compared on the following clock.
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (req_d) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else                   check("tx_data", tx_data, exp_q.pop_front());
        end
    end

    // Reference model: words the FIFO will deliver, plus frame/packet numbering.
    logic [31:0] exp_data_q[$];
    logic [7:0]  m_frame = 8'd0;
    int          m_idx = 0;
    int          last_done = -1;

    function automatic logic [31:0] make_hdr();
        return {8'hAA, CAM, m_frame, 8'(m_idx)};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill(input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom();
            fifo_q.push_back(w);
            exp_data_q.push_back(w);
            push_cnt++;
        end
    endtask

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_start_en) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("start_timeout", 32'd0, 32'd1);
        else if (last_done >= 0) check("gap_before_start", 32'((cyc - last_done - 1) >= GAP), 32'd1);
    endtask

    task automatic do_packet(input int extra, input bit fs_mid);
        bit          ok;
        bit          found;
        int          rd0;
        int          lat;
        logic [31:0] hdr;
        logic [31:0] cur[PW];
        wait_start(ok);
        if (!ok) return;
        check("tx_byte_num", 32'(tx_byte_num), 32'(BYTES));
        check("busy_in_pkt", 32'(busy), 32'd1);
        hdr = make_hdr();
        for (int i = 0; i < PW; i++) cur[i] = exp_data_q.pop_front();
        rd0 = rd_total;
        tick(1 + $urandom_range(0, 2));
        for (int i = 0; i < PW + 1 + extra; i++) begin
            exp_q.push_back(i == 0 ? hdr : (i <= PW ? cur[i-1] : cur[PW-1]));
            tx_req = 1'b1;
            if (fs_mid && i == 2) frame_start = 1'b1;
            tick();
            tx_req      = 1'b0;
            frame_start = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
        end
        tick();
        tx_done   = 1'b1;
        last_done = cyc;
        tick();
        tx_done = 1'b0;
        check("reads_per_pkt", 32'(rd_total - rd0), 32'(PW));
        m_idx++;
        if (m_idx == PPF) begin
            m_idx   = 0;
            m_frame = m_frame + 8'd1;
            found   = 1'b0;
            for (int k = 0; k < GAP + 8; k++) begin
                if (frame_done) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            lat = cyc - last_done;
            check("frame_done_lat", 32'(found && lat >= GAP + 1 && lat <= GAP + 2), 32'd1);
            check("idle_at_frame_done", 32'(busy), 32'd0);
        end
    endtask

    task automatic run_frame(input int extra, input bit fs_mid, input bit clr_te);
        int fd0;
        int s0;
        fd0 = fd_total;
        s0  = start_total;
        fill(PW * PPF);
        transfer_en = 1'b1;
        pulse_frame_start();
        for (int p = 0; p < PPF; p++) begin
            do_packet(extra, fs_mid && p == 1);
            if (clr_te && p == 0) transfer_en = 1'b0;
        end
        tick(5);
        check("frame_done_cnt", 32'(fd_total - fd0), 32'd1);
        check("starts_per_frame", 32'(start_total - s0), 32'(PPF));
        check("idle_after_frame", 32'(busy), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [31:0] hdr;
        logic [31:0] cur[PW];
        int          fd0;

        tick(2);
        check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_tx_start_en", 32'(tx_start_en), 32'd0);
        check("rst_tx_byte_num", 32'(tx_byte_num), 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // frame_start without transfer_en is ignored
        fill(PW);
        pulse_frame_start();
        tick(5);
        check("idle_te0_busy", 32'(busy), 32'd0);
        check("idle_te0_starts", 32'(start_total), 32'd0);

        // starvation: usedw below PKT_WORDS holds the source in WAIT
        fd0        = fd_total;
        usedw_hold = 1'b1;
        usedw_val  = PW - 1;
        transfer_en = 1'b1;
        pulse_frame_start();
        tick(10);
        check("starve_busy", 32'(busy), 32'd1);
        check("starve_no_start", 32'(start_total), 32'd0);
        usedw_val = PW;
        tick();
        check("start_after_fill", 32'(tx_start_en), 32'd1);
        usedw_hold = 1'b0;
        fill(PW * (PPF - 1));
        for (int p = 0; p < PPF; p++) do_packet(0, 1'b0);
        tick(5);
        check("frame0_done_cnt", 32'(fd_total - fd0), 32'd1);

        // extra tx_req beyond the payload and frame_start during SEND
        run_frame(2, 1'b1, 1'b0);

        // transfer_en dropped mid-frame: frame completes, new pulse then ignored
        run_frame(0, 1'b0, 1'b1);
        pulse_frame_start();
        tick(5);
        check("te_cleared_idle", 32'(busy), 32'd0);

        // run on past 256 frames so the header frame count wraps to 0
        for (int f = 0; f < 254; f++) run_frame($urandom_range(0, 1), 1'b0, 1'b0);

        // asynchronous reset in the middle of SEND
        fill(PW * PPF);
        transfer_en = 1'b1;
        pulse_frame_start();
        wait_start(ok);
        hdr = make_hdr();
        for (int i = 0; i < PW; i++) cur[i] = exp_data_q.pop_front();
        tick();
        exp_q.push_back(hdr);
        tx_req = 1'b1;
        tick();
        exp_q.push_back(cur[0]);
        tick();
        tx_req = 1'b0;
        tick();
        tx_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("arst_tx_start_en", 32'(tx_start_en), 32'd0);
        check("arst_tx_byte_num", 32'(tx_byte_num), 32'd0);
        check("arst_tx_data", tx_data, 32'd0);
        check("arst_frame_done", 32'(frame_done), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tx_req = 1'b0;
        for (int i = PW - 1; i >= 1; i--) exp_data_q.push_front(cur[i]);
        m_frame   = 8'd0;
        m_idx     = 0;
        last_done = -1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_no_start", 32'(tx_start_en), 32'd0);

        // next frame restarts at frame_cnt 0 and drains the unflushed words first
        run_frame(0, 1'b0, 1'b0);

        tick(5);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
